tdm_demux_rx: RTL and testbench
===============================

Name: tdm_demux_rx

Overview:
Receive side of the team's single-line time-division multiplexed link. A transmitter places one channel bit per clock slot on a serial line, with a sync strobe marking slot 0 of each frame. This block finds and tracks frame alignment, and distributes the slot bits to a parallel per-channel output register. It reports lock status and alignment errors.

Parameters:
NCH, 4, channels (slots) per frame; legal range 2..16
LOCK_FRAMES, 2, consecutive correctly placed syncs required to declare lock; legal range 1..7

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  slot enable; when low, no sampling and all counters and state hold
sdata_in  input  1  serial slot data, sampled on rising clk when ena=1
sync_in  input  1  frame strobe, high in slot 0 of each frame
ch_out  output  NCH  last accepted frame; bit i = slot i
frame_valid  output  1  one-cycle pulse when ch_out is updated
locked  output  1  high while the state machine is in LOCKED
sync_err  output  1  one-cycle pulse on an alignment error while LOCKED

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state HUNT, slot_cnt=0, good_cnt=0, shift register=0, ch_out=0, frame_valid=0, locked=0, sync_err=0. Assertion mid-frame clears everything immediately. The partial frame is discarded.
- All activity is qualified by ena=1. With ena=0, frame_valid and sync_err drop to 0 and everything else holds.
- Frame length L = NCH slots (NCH+1 with the optional feature). slot_cnt counts 0..L-1 and then wraps to 0.
- Every sampled slot writes sdata_in into assembly bit slot_cnt.
- Expected sync: slot_cnt==0. An error is either of:
  - sync_in=0 at the expected slot
  - sync_in=1 at any other slot
- HUNT:
  - Ignores sdata_in until sync_in=1.
  - On sync_in=1: captures the bit as slot 0, sets slot_cnt=1, good_cnt=1.
  - If LOCK_FRAMES==1, goes to LOCKED; otherwise goes to CHECK.
- CHECK:
  - At an expected slot with sync present: good_cnt++. On reaching LOCK_FRAMES, goes to LOCKED on that same edge.
  - Any error: go to HUNT. No sync_err pulse.
  - Completed frames are discarded.
- LOCKED:
  - On sampling slot L-1 with the frame accepted: ch_out updates on that edge and frame_valid is high for the following cycle.
  - Any error: sync_err pulses for one cycle, locked falls on the same edge, next state is HUNT, ch_out holds.
  - The misplaced or missing-sync slot is never reused as a new frame start.
- locked is the registered state decode. There is no combinational path from inputs to outputs.
- Latency: the final slot is sampled at edge k; ch_out, frame_valid and sync_err are all valid after edge k.
- Consecutive accepted frames give a frame_valid pulse every L enabled cycles.
- good_cnt saturates at LOCK_FRAMES.

Optional Feature:
TDM_PARITY_EN
- Defined:
  - L = NCH+1. Slot NCH carries even parity over slots 0..NCH-1; the parity bit is not presented on ch_out.
  - Extra output port parity_err (1 bit, reset 0).
  - In LOCKED, a parity mismatch at the final slot pulses parity_err for one cycle. ch_out is not updated and frame_valid stays low. Lock is retained.
- Undefined: L = NCH, no parity_err port, no parity check.

Test Plan:
1. Reset check: hold rst_n=0 while toggling sdata_in and sync_in -> ch_out=0, frame_valid=0, locked=0, sync_err=0. Release, then assert rst_n=0 mid-frame between edges -> outputs clear immediately.
2. Lock acquisition (NCH=4, LOCK_FRAMES=2): sync at cycles 0, 4, 8, 12; frame B data (cycles 4..7) slot0..3 = 1,0,1,1.
   - locked rises after the cycle-4 edge.
   - ch_out=4'b1101 and frame_valid=1 in cycle 8.
   - Frame A is never output.
3. Missing sync while locked: omit sync at cycle 12 -> sync_err=1 for one cycle, locked=0, ch_out holds 4'b1101. Relock needs two good syncs.
4. Spurious sync while locked: sync_in=1 at slot 2 -> sync_err pulse, HUNT, no frame_valid for that frame.
5. ena gating: drop ena for 3 cycles after slot 1 of a locked frame with data 0,1,1,0 -> no error, ch_out=4'b0110 with a single frame_valid pulse after the resumed slots.
6. TDM_PARITY_EN: locked frame data 1,1,0,0 with parity 1 -> parity_err pulses, ch_out unchanged, locked stays 1. Repeat with parity 0 -> ch_out=4'b0011 with frame_valid.

Source files
------------

// File: rtl/tdm_demux_rx_if.sv
// tdm_demux_rx_if: serial TDM receive link bundle.
//   ena         slot enable (drives sampling and all counters)
//   sdata_in    serial slot data
//   sync_in     frame strobe, high in slot 0
//   ch_out      last accepted frame, bit i = slot i
//   frame_valid one-cycle pulse when ch_out updates
//   locked      receiver is frame-aligned
//   sync_err    one-cycle pulse on an alignment error while locked
//   parity_err  one-cycle pulse on a frame parity mismatch while locked
//               (present only when TDM_PARITY_EN is defined)
// master: the transmitter / consumer side; slave: the receiver block.
interface tdm_demux_rx_if #(
  parameter int NCH = 4
);
  logic           ena;
  logic           sdata_in;
  logic           sync_in;
  logic [NCH-1:0] ch_out;
  logic           frame_valid;
  logic           locked;
  logic           sync_err;
`ifdef TDM_PARITY_EN
  logic           parity_err;

  modport master (
    output ena, sdata_in, sync_in,
    input  ch_out, frame_valid, locked, sync_err, parity_err
  );
  modport slave (
    input  ena, sdata_in, sync_in,
    output ch_out, frame_valid, locked, sync_err, parity_err
  );
`else
  modport master (
    output ena, sdata_in, sync_in,
    input  ch_out, frame_valid, locked, sync_err
  );
  modport slave (
    input  ena, sdata_in, sync_in,
    output ch_out, frame_valid, locked, sync_err
  );
`endif
endinterface

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: receive side of the single-line TDM link. Finds and tracks
// frame alignment from the sync strobe and distributes slot bits into a
// parallel per-channel register.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    tdm_demux_rx_if.slave (ena, sdata_in, sync_in in;
//          ch_out, frame_valid, locked, sync_err [, parity_err] out)
//
// Parameters:
//   NCH          channels (slots) per frame, 2..16
//   LOCK_FRAMES  consecutive good syncs needed to lock, 1..7
//
// Build option TDM_PARITY_EN: frame grows to NCH+1 slots, the last slot
// carries even parity over the data slots and a mismatch while locked
// pulses parity_err instead of updating ch_out.
//
// State   | meaning
// --------+---------------------------------------------------------
// HUNT    | no alignment; waiting for a sync strobe to start a frame
// CHECK   | tentative alignment; counting consecutive good syncs
// LOCKED  | aligned; frames are delivered to ch_out
module tdm_demux_rx #(
  parameter int NCH         = 4,
  parameter int LOCK_FRAMES = 2
) (
  input logic            clk,
  input logic            rst_n,
  tdm_demux_rx_if.slave  bus
);

`ifdef TDM_PARITY_EN
  localparam int L = NCH + 1;
`else
  localparam int L = NCH;
`endif
  localparam int            CW   = $clog2(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);
  localparam logic [2:0]    LF   = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  slot_cnt;
  logic [2:0]     good_cnt;
  logic [L-1:0]   asm_q;
  logic [NCH-1:0] ch_q;
  logic           frame_valid_q;
  logic           sync_err_q;

  logic [L-1:0]   frame_word;
  logic [CW-1:0]  next_slot;
  logic [2:0]     good_inc;
  logic           at_sync_slot;
  logic           align_err;
`ifdef TDM_PARITY_EN
  logic           parity_err_q;
  logic           frame_ok;
`endif

  // frame_word is the assembly register with the slot being sampled now
  // merged in, so the final slot can be delivered on the same edge.
  always_comb begin
    frame_word           = asm_q;
    frame_word[slot_cnt] = bus.sdata_in;
    at_sync_slot         = (slot_cnt == '0);
    align_err            = at_sync_slot ? !bus.sync_in : bus.sync_in;
    next_slot            = (slot_cnt == LAST) ? '0 : slot_cnt + CW'(1);
    good_inc             = (good_cnt >= LF) ? LF : good_cnt + 3'd1;
`ifdef TDM_PARITY_EN
    // Even parity across data plus parity slot means the whole word XORs to 0.
    frame_ok             = ~(^frame_word);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      slot_cnt      <= '0;
      good_cnt      <= '0;
      asm_q         <= '0;
      ch_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      if (bus.ena) begin
        case (state)
          HUNT: begin
            if (bus.sync_in) begin
              asm_q[0] <= bus.sdata_in;
              slot_cnt <= CW'(1);
              good_cnt <= 3'd1;
              state    <= (LOCK_FRAMES == 1) ? LOCKED : CHECK;
            end
          end

          CHECK: begin
            if (align_err) begin
              state    <= HUNT;
              slot_cnt <= '0;
              good_cnt <= '0;
            end else begin
              asm_q[slot_cnt] <= bus.sdata_in;
              slot_cnt        <= next_slot;
              if (at_sync_slot) begin
                good_cnt <= good_inc;
                if (good_inc == LF) state <= LOCKED;
              end
            end
          end

          LOCKED: begin
            if (align_err) begin
              // The offending slot is dropped; HUNT waits for a fresh sync.
              sync_err_q <= 1'b1;
              state      <= HUNT;
              slot_cnt   <= '0;
              good_cnt   <= '0;
            end else begin
              asm_q[slot_cnt] <= bus.sdata_in;
              slot_cnt        <= next_slot;
              if (at_sync_slot) good_cnt <= good_inc;
              if (slot_cnt == LAST) begin
`ifdef TDM_PARITY_EN
                if (frame_ok) begin
                  ch_q          <= frame_word[NCH-1:0];
                  frame_valid_q <= 1'b1;
                end else begin
                  parity_err_q  <= 1'b1;
                end
`else
                ch_q          <= frame_word[NCH-1:0];
                frame_valid_q <= 1'b1;
`endif
              end
            end
          end

          default: begin
            state    <= HUNT;
            slot_cnt <= '0;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.ch_out      = ch_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state == LOCKED);
`ifdef TDM_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: directed bench for tdm_demux_rx (NCH=4, LOCK_FRAMES=2).
// Covers reset, lock acquisition, missing and spurious sync, ena gating,
// parity handling when TDM_PARITY_EN is defined, and async reset mid-frame.
module tb_tdm_demux_rx;
  localparam int NCH = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  tdm_demux_rx_if #(.NCH(NCH)) bus ();

  tdm_demux_rx #(.NCH(NCH), .LOCK_FRAMES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one slot, take one rising edge, settle 1 time unit past it.
  task automatic slot(input logic en, input logic sy, input logic d);
    bus.ena      = en;
    bus.sync_in  = sy;
    bus.sdata_in = d;
    @(posedge clk);
    #1;
  endtask

  // Slots 1..NCH-1 of a frame plus the correct parity slot when enabled.
  task automatic tail(input logic [NCH-1:0] d);
    for (int i = 1; i < NCH; i++) slot(1'b1, 1'b0, d[i]);
`ifdef TDM_PARITY_EN
    slot(1'b1, 1'b0, ^d);
`endif
  endtask

  task automatic frame(input logic [NCH-1:0] d);
    slot(1'b1, 1'b1, d[0]);
    tail(d);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.ena      = 1'b1;
    bus.sync_in  = 1'b0;
    bus.sdata_in = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) slot(1'b1, i[0], ~i[0]);
    chk("rst_ch_out", 32'(bus.ch_out), 32'h0);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
    rst_n = 1'b1;

    // Lock acquisition: frame A in CHECK is never output.
    frame(4'b0110);
    chk("a_locked", 32'(bus.locked), 32'd0);
    chk("a_fv", 32'(bus.frame_valid), 32'd0);
    chk("a_ch_out", 32'(bus.ch_out), 32'h0);
    slot(1'b1, 1'b1, 1'b1);
    chk("b_locked_rise", 32'(bus.locked), 32'd1);
    tail(4'b1101);
    chk("b_ch_out", 32'(bus.ch_out), 32'hd);
    chk("b_fv", 32'(bus.frame_valid), 32'd1);
    frame(4'b1101);
    chk("c_ch_out", 32'(bus.ch_out), 32'hd);

    // Missing sync while locked.
    slot(1'b1, 1'b0, 1'b0);
    chk("miss_sync_err", 32'(bus.sync_err), 32'd1);
    chk("miss_locked", 32'(bus.locked), 32'd0);
    chk("miss_ch_hold", 32'(bus.ch_out), 32'hd);
    chk("miss_fv", 32'(bus.frame_valid), 32'd0);
    slot(1'b1, 1'b0, 1'b0);
    chk("miss_err_pulse", 32'(bus.sync_err), 32'd0);
    frame(4'b0000);
    chk("relock1_locked", 32'(bus.locked), 32'd0);
    slot(1'b1, 1'b1, 1'b0);
    chk("relock2_locked", 32'(bus.locked), 32'd1);
    tail(4'b0010);
    chk("relock_ch_out", 32'(bus.ch_out), 32'h2);
    chk("relock_fv", 32'(bus.frame_valid), 32'd1);

    // Spurious sync at slot 2 while locked.
    slot(1'b1, 1'b1, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
    slot(1'b1, 1'b1, 1'b0);
    chk("spur_sync_err", 32'(bus.sync_err), 32'd1);
    chk("spur_locked", 32'(bus.locked), 32'd0);
    chk("spur_fv", 32'(bus.frame_valid), 32'd0);
    slot(1'b1, 1'b0, 1'b1);
    chk("spur_err_pulse", 32'(bus.sync_err), 32'd0);
    chk("spur_no_fv", 32'(bus.frame_valid), 32'd0);
    chk("spur_ch_hold", 32'(bus.ch_out), 32'h2);

    // ena gating in a locked frame with data 0,1,1,0.
    frame(4'b1111);
    slot(1'b1, 1'b1, 1'b0);
    chk("ena_locked", 32'(bus.locked), 32'd1);
    slot(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      slot(1'b0, 1'b1, 1'b1);
      chk("ena_hold_err", 32'(bus.sync_err), 32'd0);
      chk("ena_hold_fv", 32'(bus.frame_valid), 32'd0);
    end
    chk("ena_hold_locked", 32'(bus.locked), 32'd1);
    slot(1'b1, 1'b0, 1'b1);
    chk("ena_slot2_fv", 32'(bus.frame_valid), 32'd0);
    slot(1'b1, 1'b0, 1'b0);
`ifdef TDM_PARITY_EN
    slot(1'b1, 1'b0, 1'b0);
`endif
    chk("ena_ch_out", 32'(bus.ch_out), 32'h6);
    chk("ena_fv", 32'(bus.frame_valid), 32'd1);
    chk("ena_err", 32'(bus.sync_err), 32'd0);
    slot(1'b0, 1'b0, 1'b0);
    chk("ena_fv_drop", 32'(bus.frame_valid), 32'd0);

`ifdef TDM_PARITY_EN
    // Data 1,1,0,0 with wrong parity 1, then correct parity 0.
    slot(1'b1, 1'b1, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b1);
    chk("par_bad_err", 32'(bus.parity_err), 32'd1);
    chk("par_bad_fv", 32'(bus.frame_valid), 32'd0);
    chk("par_bad_ch", 32'(bus.ch_out), 32'h6);
    chk("par_bad_locked", 32'(bus.locked), 32'd1);
    slot(1'b1, 1'b1, 1'b1);
    chk("par_err_pulse", 32'(bus.parity_err), 32'd0);
    slot(1'b1, 1'b0, 1'b1);
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b0);
    chk("par_good_err", 32'(bus.parity_err), 32'd0);
    chk("par_good_ch", 32'(bus.ch_out), 32'h3);
    chk("par_good_fv", 32'(bus.frame_valid), 32'd1);
`endif

    // Async reset between edges, mid-frame while locked.
    frame(4'b1001);
    chk("pre_rst_ch", 32'(bus.ch_out), 32'h9);
    slot(1'b1, 1'b1, 1'b1);
    slot(1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ch_out", 32'(bus.ch_out), 32'h0);
    chk("async_locked", 32'(bus.locked), 32'd0);
    chk("async_fv", 32'(bus.frame_valid), 32'd0);
    chk("async_err", 32'(bus.sync_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Remainder of the interrupted frame must not complete anything.
    tail(4'b1111);
    chk("post_rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("post_rst_locked", 32'(bus.locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
